// File: rtl/bcd_scan_counter.sv
// Decimal up/down counter with time-multiplexed, active-low 7-segment scan output.
// Optional leading-zero blanking is enabled with `define BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 131072,
  parameter int MAX_VAL    = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    tick_led,
  output logic                    wrap
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
    logic [4*NUM_DIGITS-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [4*NUM_DIGITS-1:0] MAX_BCD = to_bcd(MAX_VAL);

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0: return 8'h81;
      4'd1: return 8'hCF;
      4'd2: return 8'h92;
      4'd3: return 8'h86;
      4'd4: return 8'hCC;
      4'd5: return 8'hA4;
      4'd6: return 8'hA0;
      4'd7: return 8'h8F;
      4'd8: return 8'h80;
      4'd9: return 8'h84;
      default: return 8'hFF;
    endcase
  endfunction

  logic [TW-1:0]           tick_cnt;
  logic                    tick_hit;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] bcd_nxt;
  logic                    wrap_nxt;
  logic                    carry;
  logic [SW-1:0]           scan_cnt;
  logic                    scan_adv;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nxt;
  logic [NUM_DIGITS-1:0]   blank_v;
  logic                    all_zero;
  logic [7:0]              seg_nxt;

  // A clear in the terminal prescaler cycle swallows that tick completely.
  assign tick_hit = en && (tick_cnt == TW'(TICK_DIV - 1));
  assign tick     = tick_hit && !clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          tick_cnt <= '0;
    else if (clr)      tick_cnt <= '0;
    else if (tick_hit) tick_cnt <= '0;
    else if (en)       tick_cnt <= tick_cnt + TW'(1);
  end

  always_comb begin
    bcd_nxt  = bcd;
    wrap_nxt = 1'b0;
    carry    = 1'b1;
    if (clr) begin
      bcd_nxt = '0;
    end else if (tick) begin
      if (up) begin
        if (bcd == MAX_BCD) begin
          bcd_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
              if (bcd[4*i +: 4] >= 4'd9) bcd_nxt[4*i +: 4] = 4'd0;
              else begin
                bcd_nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                carry             = 1'b0;
              end
            end
          end
        end
      end else begin
        if (bcd == '0) begin
          bcd_nxt  = MAX_BCD;
          wrap_nxt = 1'b1;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
              if (bcd[4*i +: 4] == 4'd0) bcd_nxt[4*i +: 4] = 4'd9;
              else begin
                bcd_nxt[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                carry             = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd      <= '0;
      wrap     <= 1'b0;
      tick_led <= 1'b0;
    end else begin
      bcd  <= bcd_nxt;
      wrap <= wrap_nxt;
      if (tick) tick_led <= ~tick_led;
    end
  end

  assign scan_adv = (scan_cnt == SW'(SCAN_DIV - 1));

  always_comb begin
    idx_nxt = idx;
    if (scan_adv) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Blank flags: a digit is a leading zero if it and everything above it are 0.
  always_comb begin
    blank_v  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (bcd_nxt[4*i +: 4] == 4'd0);
      blank_v[i] = all_zero && (i != 0);
    end
  end

  // seg is built from next-cycle bcd and index so seg, an and bcd always agree.
  always_comb begin
    seg_nxt = decode(bcd_nxt[4*int'(idx_nxt) +: 4]);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (blank_v[idx_nxt]) seg_nxt = 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= 8'hFF;
    end else begin
      scan_cnt <= scan_adv ? '0 : scan_cnt + SW'(1);
      idx      <= idx_nxt;
      an       <= ~(NUM_DIGITS'(1) << idx_nxt);
      seg      <= seg_nxt;
    end
  end

  // Only consumed by the optional blanking build.
  logic unused_blank;
  assign unused_blank = ^blank_v;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (3 digits, TICK_DIV=4, SCAN_DIV=2, MAX_VAL=200).
// Honours `define BCD_SCAN_LEADING_ZERO_BLANK_EN to expect blanked leading zeros.
module tb_bcd_scan_counter;

  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          up  = 1'b1;
  logic          clr = 1'b0;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic [4*ND-1:0] bcd;
  logic          tick_led;
  logic          wrap;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  logic exp_led = 1'b0;
  logic [10:0] exp_q[$];

  bcd_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(4), .SCAN_DIV(2), .MAX_VAL(200)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .seg(seg), .an(an), .bcd(bcd), .tick_led(tick_led), .wrap(wrap)
  );

  // Clock and reset-relative edge counter (drives the scan model)
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  // Driver tasks
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    clk_n(4 * n);
    if (n % 2 == 1) exp_led = ~exp_led;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    clk_n(1);
    clr = 1'b0;
  endtask

  function automatic logic [7:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 8'h81;  4'd1: return 8'hCF;  4'd2: return 8'h92;
      4'd3: return 8'h86;  4'd4: return 8'hCC;  4'd5: return 8'hA4;
      4'd6: return 8'hA0;  4'd7: return 8'h8F;  4'd8: return 8'h80;
      4'd9: return 8'h84;  default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [11:0] val, input int i);
    logic [11:0] sh;
    sh = val >> (4 * i);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (i > 0 && sh == 12'h000) return 8'hFF;
`endif
    return dec(sh[3:0]);
  endfunction

  // Scoreboard: predict six scan samples from the edge count, then compare in order
  task automatic scan_check(input logic [11:0] val, input string tag);
    int c0;
    int ix;
    logic [10:0] e;
    c0 = cyc;
    for (int k = 1; k <= 6; k++) begin
      ix = ((c0 + k) / 2) % 3;
      exp_q.push_back({~(3'b001 << ix), exp_seg(val, ix)});
    end
    for (int k = 0; k < 6; k++) begin
      clk_n(1);
      e = exp_q.pop_front();
      check({tag, "_an"},  32'(an),  32'(e[10:8]));
      check({tag, "_seg"}, 32'(seg), 32'(e[7:0]));
    end
  endtask

  initial begin
    en = 1'b1;
    up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg",  32'(seg), 32'hFF);
    check("rst_an",   32'(an),  32'h7);
    check("rst_bcd",  32'(bcd), 32'h0);
    check("rst_led",  32'(tick_led), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b1;
    run_ticks(57);
    check("cnt57", 32'(bcd), 32'h057);
    check("led57", 32'(tick_led), 32'(exp_led));

    // asynchronous reset mid-count
    clk_n(2);
    rst = 1'b0;
    #1;
    check("arst_seg",  32'(seg), 32'hFF);
    check("arst_an",   32'(an),  32'h7);
    check("arst_bcd",  32'(bcd), 32'h0);
    check("arst_led",  32'(tick_led), 32'h0);
    check("arst_wrap", 32'(wrap), 32'h0);
    #2;
    rst = 1'b1;
    exp_led = 1'b0;
    clk_n(3);
    check("rel_3clk", 32'(bcd), 32'h000);
    clk_n(1);
    exp_led = ~exp_led;
    check("rel_4clk", 32'(bcd), 32'h001);
    check("rel_led",  32'(tick_led), 32'(exp_led));

    // up count through 199 -> 200 -> wrap to 000
    do_clr();
    run_ticks(199);
    check("up199", 32'(bcd), 32'h199);
    check("led199", 32'(tick_led), 32'(exp_led));
    run_ticks(1);
    check("up200", 32'(bcd), 32'h200);
    check("up200_wrap", 32'(wrap), 32'h0);
    check("led200", 32'(tick_led), 32'(exp_led));
    clk_n(3);
    check("pre_wrap", 32'(wrap), 32'h0);
    clk_n(1);
    exp_led = ~exp_led;
    check("upwrap_bcd",  32'(bcd), 32'h000);
    check("upwrap_wrap", 32'(wrap), 32'h1);
    check("upwrap_led",  32'(tick_led), 32'(exp_led));
    clk_n(1);
    check("upwrap_1cyc", 32'(wrap), 32'h0);

    // down count: 000 -> 200 (wrap) -> 199 (double borrow)
    up = 1'b0;
    do_clr();
    run_ticks(1);
    check("dn_wrap_bcd", 32'(bcd), 32'h200);
    check("dn_wrap",     32'(wrap), 32'h1);
    clk_n(1);
    check("dn_wrap_1cyc", 32'(wrap), 32'h0);
    clk_n(3);
    exp_led = ~exp_led;
    check("dn199", 32'(bcd), 32'h199);
    check("dn199_wrap", 32'(wrap), 32'h0);
    check("dn199_led", 32'(tick_led), 32'(exp_led));

    // hold with en=0, scan keeps running; then clear in the tick cycle
    up = 1'b1;
    do_clr();
    run_ticks(42);
    check("cnt42", 32'(bcd), 32'h042);
    en = 1'b0;
    scan_check(12'h042, "hold_scan");
    clk_n(14);
    check("hold_bcd", 32'(bcd), 32'h042);
    en = 1'b1;
    clk_n(3);
    check("hold_frozen", 32'(bcd), 32'h042);
    clk_n(1);
    exp_led = ~exp_led;
    check("hold_resume", 32'(bcd), 32'h043);
    check("hold_led", 32'(tick_led), 32'(exp_led));
    clk_n(3);
    clr = 1'b1;
    clk_n(1);
    clr = 1'b0;
    check("clrtick_bcd",  32'(bcd), 32'h000);
    check("clrtick_wrap", 32'(wrap), 32'h0);
    check("clrtick_led",  32'(tick_led), 32'(exp_led));
    clk_n(3);
    check("clrtick_quiet", 32'(bcd), 32'h000);
    clk_n(1);
    exp_led = ~exp_led;
    check("clr_resume", 32'(bcd), 32'h001);

    // scan round at 123
    do_clr();
    run_ticks(123);
    en = 1'b0;
    check("cnt123", 32'(bcd), 32'h123);
    scan_check(12'h123, "scan123");

    // leading zero handling at 007 and 000
    en = 1'b1;
    do_clr();
    run_ticks(7);
    en = 1'b0;
    check("cnt007", 32'(bcd), 32'h007);
    scan_check(12'h007, "scan007");
    do_clr();
    scan_check(12'h000, "scan000");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Parametrised decimal up/down counter with a time-multiplexed 7-segment driver.
- An internal prescaler turns the system clock into count ticks. A BCD register counts modulo MAX_VAL+1.
- A scan prescaler rotates active-low digit enables over NUM_DIGITS digits.
- Sits between board clock/buttons and the seven-segment header; supersedes fixed 4-digit, count-up-only counters.

Parameters:
- NUM_DIGITS, 4, number of displayed BCD digits; legal 1..8.
- TICK_DIV, 100000000, clk cycles per count tick; legal >=2.
- SCAN_DIV, 131072, clk cycles each digit stays enabled; legal >=2.
- MAX_VAL, 200, terminal count (decimal); legal 1..10^NUM_DIGITS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; 0 freezes prescaler and count.
- up  in  1  direction: 1 = count up, 0 = count down.
- clr  in  1  synchronous clear.
- seg  out  8  segment pattern, active low; bit7 = dp, bits6..0 = a..g.
- an  out  NUM_DIGITS  digit enables, active low; bit0 = least significant digit.
- bcd  out  4*NUM_DIGITS  current count, packed BCD, digit0 in [3:0].
- tick_led  out  1  toggles on every count tick.
- wrap  out  1  one-cycle pulse on a wrap-around tick.

Behaviour:
- Reset (rst=0, async): seg=8'hFF, an=all ones, bcd=0, tick_led=0, wrap=0. Prescalers and scan index=0. All outputs are registered.
- Priority each clk: clr > tick > hold.
- Prescaler: counts 0..TICK_DIV-1 while en=1 and holds while en=0. tick=1 in the cycle it equals TICK_DIV-1, after which it reloads to 0.
- On tick, up=1:
  - if bcd==MAX_VAL: bcd<=0 and wrap<=1;
  - else BCD increment, digit 9 rolls to 0 with carry into the next digit.
- On tick, up=0:
  - if bcd==0: bcd<=MAX_VAL (BCD form) and wrap<=1;
  - else BCD decrement, digit 0 rolls to 9 with borrow.
- tick_led toggles on every tick, wrapping or not. wrap is 0 in every non-wrapping cycle.
- bcd reflects the new value one cycle after the tick cycle.
- clr=1: bcd<=0, prescaler<=0, wrap<=0, tick_led unchanged. clr coincident with a tick suppresses the tick entirely.
- up may change at any time; the value sampled in the tick cycle applies.
- No digit ever exceeds 9. Any internal non-BCD digit decodes to blank (8'hFF).
- Scan:
  - Free-running counter 0..SCAN_DIV-1, unaffected by en and clr.
  - At its terminal value, index advances 0->1->...->NUM_DIGITS-1->0.
  - an has exactly one 0, at bit [index].
  - seg = decode(bcd digit[index]).
  - an and seg update in the same clk edge, so there is never a cycle where an and seg refer to different digits.
- Decode, active low: 0=81 1=CF 2=92 3=86 4=CC 5=A4 6=A0 7=8F 8=80 9=84 (hex). dp is always off (bit7=1).
- Async reset asserted mid-count or mid-scan forces reset values immediately. Counting resumes from 0 on the first clk after release.

Optional Feature:
- Macro: BCD_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: a digit is blanked (seg=8'hFF while its an stays active) when it and every more-significant digit are 0. Digit0 is never blanked, so a count of 0 shows a single "0".
- Undefined: every digit, including leading zeros, shows its decoded value.
- bcd, wrap and an timing are identical in both builds.

Test Plan (NUM_DIGITS=3, TICK_DIV=4, SCAN_DIV=2, MAX_VAL=200 unless stated):
- Drive rst=0 mid-count at bcd=12'h057 -> same timestep: seg=FF, an=3'b111, bcd=0, tick_led=0, wrap=0; after release with en=1,up=1, bcd=12'h001 after 4 clks.
- Count up from 12'h199 -> next tick gives 12'h200 with no wrap; following tick gives 12'h000 with wrap high exactly 1 cycle; tick_led toggles on both ticks.
- Count down from 12'h000 -> tick gives 12'h200 with wrap pulse; next tick gives 12'h199, exercising borrow through two digits.
- Hold en=0 for 20 clks at 12'h042 -> bcd unchanged and prescaler frozen, while an keeps rotating 110,101,011 each held 2 clks; assert clr in the exact tick cycle -> bcd=0, no wrap.
- Load bcd=12'h123 and observe one scan round -> (an,seg) = (110,86), (101,92), (011,CF), seg changing on the same edge as an.
- Build with BCD_SCAN_LEADING_ZERO_BLANK_EN, bcd=12'h007 -> digit0 seg=8F, digits1-2 seg=FF; bcd=12'h000 -> digit0 seg=81, others FF. Without the macro -> digits1-2 seg=81.
